// File: rtl/sprite_motion_ctrl_if.sv
// Interface for the sprite motion controller: frame strobe, freeze, direction buttons in;
// position, speed, hit pulses and moving flag out. Clock and reset stay plain ports.
interface sprite_motion_ctrl_if #(
    parameter int COORD_W = 10,
    parameter int SPD_W   = 3
);
    logic               iFrame_tick;
    logic               iFreeze;
    logic               iSlider_go;
    logic               iSlider_back;
    logic               iSlider_up;
    logic               iSlider_down;
    logic [COORD_W-1:0] oSlider_x;
    logic [COORD_W-1:0] oSlider_y;
    logic [SPD_W-1:0]   oSpeed_x;
    logic [SPD_W-1:0]   oSpeed_y;
    logic [3:0]         oHit;
    logic               oMoving;

    modport master (
        output iFrame_tick, iFreeze, iSlider_go, iSlider_back, iSlider_up, iSlider_down,
        input  oSlider_x, oSlider_y, oSpeed_x, oSpeed_y, oHit, oMoving
    );

    modport slave (
        input  iFrame_tick, iFreeze, iSlider_go, iSlider_back, iSlider_up, iSlider_down,
        output oSlider_x, oSlider_y, oSpeed_x, oSpeed_y, oHit, oMoving
    );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Two-axis sprite position controller: per-axis accelerate/cruise FSM advanced on frame
// ticks, with clamp or knock-back at the bounds and one-cycle per-edge hit pulses.
module sprite_motion_ctrl #(
    parameter int COORD_W     = 10,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 600,
    parameter int Y_MIN       = 8,
    parameter int Y_MAX       = 460,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 400,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 4,
    parameter int KNOCKBACK   = 0,
    parameter int SPD_W       = $clog2(MAX_SPEED + 1)
) (
    input  logic                 iVGA_CLK,
    input  logic                 iRST,
    sprite_motion_ctrl_if.slave  bus
);
    localparam int PW    = COORD_W + 2;
    localparam int CNT_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEL  = 2'd1,
        ST_CRUISE = 2'd2
    } state_e;

    // dir: 0 = towards MAX, 1 = towards MIN
    typedef struct packed {
        state_e             st;
        logic               dir;
        logic [SPD_W-1:0]   spd;
        logic [CNT_W-1:0]   cnt;
        logic [COORD_W-1:0] pos;
        logic               hit_lo;
        logic               hit_hi;
    } axis_t;

    localparam axis_t X_RST = '{st: ST_IDLE, dir: 1'b0, spd: '0, cnt: '0,
                                pos: COORD_W'(X_INIT), hit_lo: 1'b0, hit_hi: 1'b0};
    localparam axis_t Y_RST = '{st: ST_IDLE, dir: 1'b0, spd: '0, cnt: '0,
                                pos: COORD_W'(Y_INIT), hit_lo: 1'b0, hit_hi: 1'b0};

    function automatic axis_t axis_step(
        input axis_t              cur,
        input logic               cmd_p,
        input logic               cmd_n,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        axis_t                 nx;
        logic signed [PW-1:0]  mag;
        logic signed [PW-1:0]  nxt;
        nx        = cur;
        nx.hit_lo = 1'b0;
        nx.hit_hi = 1'b0;
        if (cmd_p == cmd_n) begin
            nx.st  = ST_IDLE;
            nx.spd = '0;
            nx.cnt = '0;
        end else if ((cur.st == ST_IDLE) || (cmd_n != cur.dir)) begin
            nx.st  = (MAX_SPEED == 1) ? ST_CRUISE : ST_ACCEL;
            nx.dir = cmd_n;
            nx.spd = SPD_W'(1);
            nx.cnt = '0;
        end else if (cur.st == ST_ACCEL) begin
            if (cur.cnt == CNT_W'(ACCEL_TICKS - 1)) begin
                nx.spd = cur.spd + SPD_W'(1);
                nx.cnt = '0;
                nx.st  = (nx.spd == SPD_W'(MAX_SPEED)) ? ST_CRUISE : ST_ACCEL;
            end else begin
                nx.cnt = cur.cnt + CNT_W'(1);
            end
        end else begin
            nx.st  = ST_CRUISE;
            nx.spd = SPD_W'(MAX_SPEED);
        end

        // Widened signed sum so that overshoot on either side is visible before clamping
        mag = $signed({{(PW - SPD_W){1'b0}}, nx.spd});
        nxt = $signed({2'b00, cur.pos}) + (nx.dir ? -mag : mag);
        if (nxt > $signed({2'b00, hi})) begin
            nx.pos    = hi - COORD_W'(KNOCKBACK);
            nx.st     = ST_IDLE;
            nx.spd    = '0;
            nx.cnt    = '0;
            nx.hit_hi = 1'b1;
        end else if (nxt < $signed({2'b00, lo})) begin
            nx.pos    = lo + COORD_W'(KNOCKBACK);
            nx.st     = ST_IDLE;
            nx.spd    = '0;
            nx.cnt    = '0;
            nx.hit_lo = 1'b1;
        end else begin
            nx.pos = nxt[COORD_W-1:0];
        end
        return nx;
    endfunction

    axis_t x_q, x_d;
    axis_t y_q, y_d;
    logic  moving_q, moving_d;
    logic  update_s;

    assign update_s = bus.iFrame_tick & ~bus.iFreeze;

    // Next-state for both axes; hit flags self-clear when no update occurs
    always_comb begin
        x_d        = x_q;
        x_d.hit_lo = 1'b0;
        x_d.hit_hi = 1'b0;
        y_d        = y_q;
        y_d.hit_lo = 1'b0;
        y_d.hit_hi = 1'b0;
        if (update_s) begin
            x_d = axis_step(x_q, bus.iSlider_go, bus.iSlider_back,
                            COORD_W'(X_MIN), COORD_W'(X_MAX));
            y_d = axis_step(y_q, bus.iSlider_down, bus.iSlider_up,
                            COORD_W'(Y_MIN), COORD_W'(Y_MAX));
        end else begin
            x_d.st = x_q.st;
            y_d.st = y_q.st;
        end
        moving_d = (x_d.spd != '0) || (y_d.spd != '0);
    end

    // State registers with synchronous reset taking priority over any tick
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            x_q      <= X_RST;
            y_q      <= Y_RST;
            moving_q <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            moving_q <= moving_d;
        end
    end

    assign bus.oSlider_x = x_q.pos;
    assign bus.oSlider_y = y_q.pos;
    assign bus.oSpeed_x  = x_q.spd;
    assign bus.oSpeed_y  = y_q.spd;
    assign bus.oHit      = {y_q.hit_hi, y_q.hit_lo, x_q.hit_hi, x_q.hit_lo};
    assign bus.oMoving   = moving_q;
endmodule
